// File: rtl/dmem_if.sv
// Load/store request and response bundle between the MEM stage and the data
// memory responder.
//
// Handshake: an access is accepted on a rising clk edge where req_valid and
// req_ready are both high. The requester holds req_valid and all req_* fields
// stable until the cycle in which rsp_valid is high. rsp_valid is a one-cycle
// strobe that qualifies rsp_rdata and rsp_err. stall_mem tells the pipeline to
// hold while an access is outstanding and not yet in its response cycle.
interface dmem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_wr;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  stall_mem;

    // MEM-stage side
    modport master (
        output req_valid, req_wr, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall_mem
    );

    // Memory responder side
    modport slave (
        input  req_valid, req_wr, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall_mem
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I MEM stage. Serves one load/store at a
// time from a word-organised internal RAM, applies byte-lane masks for stores,
// extracts and extends load lanes, inserts WAIT_CYCLES wait states and flags
// misaligned, illegal-funct3 and out-of-range accesses.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_if.slave      bus,
    output logic [1:0] state_dbg
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_wr;
    logic [2:0]            lat_funct3;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;

    logic [31:0]           mem [DEPTH_WORDS];

    logic                  accept;
    logic                  enter_resp;
    logic                  op_wr;
    logic [2:0]            op_funct3;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_wdata;
    logic                  op_err;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           mem_word;
    logic [3:0]            wmask;
    logic [31:0]           wlanes;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_data;
    logic [31:0]           rdata_next;

    assign accept        = bus.req_valid && (state == IDLE);
    assign bus.req_ready = (state == IDLE);
    assign bus.stall_mem = bus.req_valid && (state != RESP);
    assign state_dbg     = state;

    // The memory operation happens on the edge entering RESP. With no wait
    // states (or on an error) that edge is the accept edge itself, so the live
    // request is used in IDLE and the latched copy otherwise.
    assign op_wr     = (state == IDLE) ? bus.req_wr     : lat_wr;
    assign op_funct3 = (state == IDLE) ? bus.req_funct3 : lat_funct3;
    assign op_addr   = (state == IDLE) ? bus.req_addr   : lat_addr;
    assign op_wdata  = (state == IDLE) ? bus.req_wdata  : lat_wdata;

    assign idx      = op_addr[IDX_W+1:2];
    assign mem_word = mem[idx];

    assign enter_resp = (accept && ((WAIT_CYCLES == 0) || op_err)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    // Fault detection: illegal funct3, misalignment, word index past the RAM.
    always_comb begin
        op_err = 1'b0;
        if (op_wr) begin
            if (op_funct3 > 3'd2)                             op_err = 1'b1;
            if ((op_funct3 == 3'd1) && op_addr[0])            op_err = 1'b1;
            if ((op_funct3 == 3'd2) && (op_addr[1:0] != 2'd0)) op_err = 1'b1;
        end else begin
            case (op_funct3)
                3'd3, 3'd6, 3'd7: op_err = 1'b1;
                3'd1, 3'd5:       if (op_addr[0]) op_err = 1'b1;
                3'd2:             if (op_addr[1:0] != 2'd0) op_err = 1'b1;
                default:          ;
            endcase
        end
        if ((op_addr >> (IDX_W + 2)) != '0) op_err = 1'b1;
    end

    // Store lane mask and lane-replicated write data.
    always_comb begin
        wmask  = 4'b1111;
        wlanes = op_wdata;
        case (op_funct3[1:0])
            2'd0: begin
                wmask  = 4'b0001 << op_addr[1:0];
                wlanes = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                wmask  = op_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction with sign/zero extension.
    always_comb begin
        ld_byte = mem_word[8*op_addr[1:0] +: 8];
        ld_half = op_addr[1] ? mem_word[31:16] : mem_word[15:0];
        case (op_funct3)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_data = {16'd0, ld_half};
            3'd2:    ld_data = mem_word;
            default: ld_data = 32'd0;
        endcase
        rdata_next = (op_wr || op_err) ? 32'd0 : ld_data;
    end

    // RAM write: masked bytes only, never on an error or while in reset.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && op_wr && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    // Access FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            lat_wr        <= 1'b0;
            lat_funct3    <= 3'd0;
            lat_addr      <= '0;
            lat_wdata     <= 32'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'd0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_wr     <= bus.req_wr;
                        lat_funct3 <= bus.req_funct3;
                        lat_addr   <= bus.req_addr;
                        lat_wdata  <= bus.req_wdata;
                        cnt        <= CNT_LOAD;
                        state      <= enter_resp ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= op_err;
                bus.rsp_rdata <= rdata_next;
            end
        end
    end
endmodule
